vga_sync_gen: RTL and testbench

//  Generates VGA 640x480@60 timing for the game display from the board clock.

---
 rtl/vga_sync_gen_pkg.sv | 58 +++++
 rtl/vga_sync_gen_pix_clk_en.sv | 50 +++++
 rtl/vga_sync_gen.sv | 147 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants and small decode helpers for the sync generator
// and the downstream renderer (default 640x480@60 from a 100 MHz board clock).
package vga_sync_gen_pkg;

   // Counter width for both pixel and line counters
   localparam int CNT_W = 10;
   // Largest line or frame total the counters can represent
   localparam int CNT_MAX = 1 << CNT_W;

   // Legal range of board clocks per pixel
   localparam int DIV_MIN = 1;
   localparam int DIV_MAX = 16;

   // Default 640x480@60 timing, horizontal in pixels
   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;

   // Default vertical timing, in lines
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Sync pulses are active-low on a standard VGA monitor
   localparam bit DEF_SYNC_POL = 1'b0;

   // Derived defaults (800 pixels per line, 525 lines per frame)
   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Registered decode bundle that travels alongside the counters
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } sync_flags_t;

   // Total length of a line or frame from its four segments
   function automatic int seg_total(input int active, input int fp,
                                    input int sync_w, input int bp);
      return active + fp + sync_w + bp;
   endfunction

   // Half-open window test lo <= pos < hi; done in int so a window ending
   // exactly at CNT_MAX does not wrap
   function automatic logic in_window(input int pos, input int lo, input int hi);
      return (pos >= lo) && (pos < hi);
   endfunction

   // Map an asserted/deasserted sync state onto the pin level
   function automatic logic sync_level(input logic asserted, input logic pol);
      return asserted ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_sync_gen_pix_clk_en.sv
// Pixel-rate enable: divides the board clock by CLK_DIV and emits a single
// board-clock pulse once per pixel period. With CLK_DIV=1 the enable is high
// on every cycle after reset release.
module vga_sync_gen_pix_clk_en
   import vga_sync_gen_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic pix_en
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Reject divider settings outside the supported range at elaboration
   generate
      if ((CLK_DIV < DIV_MIN) || (CLK_DIV > DIV_MAX)) begin : g_bad_div
         $error("vga_sync_gen_pix_clk_en: CLK_DIV out of range 1..16");
      end
   endgenerate

   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_next;
   logic             pix_en_reg;

   // Divider count 0..CLK_DIV-1, wrapping
   always_comb begin
      div_next = div_reg + DIV_W'(1);
      if (div_reg == DIV_LAST) begin
         div_next = '0;
      end
   end

   // Enable is registered from the next count so it is high exactly while
   // the divider sits at its last value (and never during reset)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg    <= '0;
         pix_en_reg <= 1'b0;
      end else begin
         div_reg    <= div_next;
         pix_en_reg <= (div_next == DIV_LAST);
      end
   end

   assign pix_en = pix_en_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel enable, pixel/line counters, sync pulses,
// active-area flag and line/frame start strobes. All decoded outputs are
// registered from the next counter values so they line up with O_x/O_y.
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = DEF_SYNC_POL
) (
   input  logic             I_clk,
   input  logic             I_rst_n,
   output logic             O_pix_en,
   output logic [CNT_W-1:0] O_x,
   output logic [CNT_W-1:0] O_y,
   output logic             O_active,
   output logic             O_hs,
   output logic             O_vs,
   output logic             O_line_start,
   output logic             O_frame_start
);

   localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   // Both totals must fit the 10-bit counters
   localparam int TOTALS [2] = '{H_TOTAL, V_TOTAL};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_total_check
         if ((TOTALS[gi] > CNT_MAX) || (TOTALS[gi] < 1)) begin : g_bad_total
            $error("vga_sync_gen: line/frame total does not fit the counters");
         end
      end
   endgenerate

   logic             pix_en;
   logic [CNT_W-1:0] x_reg;
   logic [CNT_W-1:0] x_next;
   logic [CNT_W-1:0] y_reg;
   logic [CNT_W-1:0] y_next;
   logic             line_wrap;
   logic             frame_wrap;
   sync_flags_t      flags_reg;
   sync_flags_t      flags_next;
   logic             line_start_reg;
   logic             frame_start_reg;

   vga_sync_gen_pix_clk_en #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_clk_en (
      .clk    (I_clk),
      .rst_n  (I_rst_n),
      .pix_en (pix_en)
   );

   // Next raster position: advance one pixel per tick, wrap line then frame
   always_comb begin
      x_next     = x_reg;
      y_next     = y_reg;
      line_wrap  = pix_en && (x_reg == H_LAST);
      frame_wrap = line_wrap && (y_reg == V_LAST);
      if (pix_en) begin
         if (line_wrap) begin
            x_next = '0;
            if (y_reg == V_LAST) begin
               y_next = '0;
            end else begin
               y_next = y_reg + CNT_W'(1);
            end
         end else begin
            x_next = x_reg + CNT_W'(1);
         end
      end
   end

   // Decode active area and sync windows from the next position; vertical
   // sync covers whole lines, blanking pixels included
   always_comb begin
      flags_next.active = (int'(x_next) < H_ACTIVE) && (int'(y_next) < V_ACTIVE);
      flags_next.hs     = sync_level(in_window(int'(x_next), H_SYNC_START, H_SYNC_END),
                                     SYNC_POL);
      flags_next.vs     = sync_level(in_window(int'(y_next), V_SYNC_START, V_SYNC_END),
                                     SYNC_POL);
   end

   // Raster position registers; reset restarts the frame at (0,0)
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         x_reg <= '0;
         y_reg <= '0;
      end else begin
         x_reg <= x_next;
         y_reg <= y_next;
      end
   end

   // Decoded flags registered alongside the counters so there is no skew;
   // reset values match position (0,0)
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         flags_reg.active <= 1'b1;
         flags_reg.hs     <= ~SYNC_POL;
         flags_reg.vs     <= ~SYNC_POL;
      end else begin
         flags_reg <= flags_next;
      end
   end

   // Start strobes: high for the one cycle in which the wrapped position is
   // first presented; the reset-time (0,0) is not a wrap so nothing pulses
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         line_start_reg  <= line_wrap;
         frame_start_reg <= frame_wrap;
      end
   end

   assign O_pix_en      = pix_en;
   assign O_x           = x_reg;
   assign O_y           = y_reg;
   assign O_active      = flags_reg.active;
   assign O_hs          = flags_reg.hs;
   assign O_vs          = flags_reg.vs;
   assign O_line_start  = line_start_reg;
   assign O_frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance (CLK_DIV=4) and a tiny
// CLK_DIV=1 instance with positive syncs so whole frames fit in a short run.
// Each instance has a closed-form expectation (position from elapsed cycles)
// feeding a tick scoreboard and a per-cycle comparison.
module tb_vga_sync_gen;

   typedef struct packed {
      logic       pix_en;
      logic [9:0] x;
      logic [9:0] y;
      logic       active;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
   } obs_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       active;
      logic       hs;
      logic       vs;
   } tick_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic clk = 1'b0;
   logic rst_n_a;
   logic rst_n_b;

   logic       pix_en_a, active_a, hs_a, vs_a, ls_a, fs_a;
   logic [9:0] x_a, y_a;
   logic       pix_en_b, active_b, hs_b, vs_b, ls_b, fs_b;
   logic [9:0] x_b, y_b;

   always #5 clk = ~clk;

   vga_sync_gen dut_a (
      .I_clk(clk), .I_rst_n(rst_n_a), .O_pix_en(pix_en_a), .O_x(x_a), .O_y(y_a),
      .O_active(active_a), .O_hs(hs_a), .O_vs(vs_a),
      .O_line_start(ls_a), .O_frame_start(fs_a)
   );

   vga_sync_gen #(
      .CLK_DIV(1), .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
   ) dut_b (
      .I_clk(clk), .I_rst_n(rst_n_b), .O_pix_en(pix_en_b), .O_x(x_b), .O_y(y_b),
      .O_active(active_b), .O_hs(hs_b), .O_vs(vs_b),
      .O_line_start(ls_b), .O_frame_start(fs_b)
   );

   task automatic check(input string name, input int got, input int expv);
      total++;
      if (got != expv) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, expv);
      end
   endtask

   task automatic check_obs(input string name, input obs_t got, input obs_t e);
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL %s @%0d: got en=%0b x=%0d y=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b, expected en=%0b x=%0d y=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
                  name, cyc, got.pix_en, got.x, got.y, got.active, got.hs, got.vs, got.ls, got.fs,
                  e.pix_en, e.x, e.y, e.active, e.hs, e.vs, e.ls, e.fs);
      end
   endtask

   // Pixel ticks consumed after n clock edges since reset release
   function automatic int ticks_at(input int n, input int d);
      if (n <= 0) return 0;
      return (d == 1) ? (n - 1) : (n / d);
   endfunction

   function automatic obs_t model(input int n, input int d, input int ha, input int hf,
                                  input int hsw, input int hb, input int va, input int vf,
                                  input int vsw, input int vb, input bit pol);
      obs_t e;
      int ht, vt, t, p, xi, yi;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      t  = ticks_at(n, d);
      p  = t % (ht * vt);
      xi = p % ht;
      yi = p / ht;
      e.pix_en = (n > 0) && ((d == 1) || ((n % d) == d - 1));
      e.x      = 10'(xi);
      e.y      = 10'(yi);
      e.active = (xi < ha) && (yi < va);
      e.hs     = ((xi >= ha + hf) && (xi < ha + hf + hsw)) ? pol : ~pol;
      e.vs     = ((yi >= va + vf) && (yi < va + vf + vsw)) ? pol : ~pol;
      e.ls     = (t != ticks_at(n - 1, d)) && (xi == 0);
      e.fs     = e.ls && (yi == 0);
      return e;
   endfunction

   function automatic obs_t model_a(input int n);
      return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic obs_t model_b(input int n);
      return model(n, 1, 12, 2, 3, 3, 4, 1, 2, 1, 1'b1);
   endfunction

   int    n_a, n_b;
   obs_t  exp_a, exp_b;
   tick_t q_a[$];
   tick_t q_b[$];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Expectation generator A: pushes one entry per expected pixel tick
   initial begin
      n_a   = 0;
      exp_a = model_a(0);
      forever begin
         @(posedge clk or negedge rst_n_a);
         if (!rst_n_a) begin
            check("drained_at_reset_a", q_a.size(), 0);
            q_a.delete();
            n_a   = 0;
            exp_a = model_a(0);
         end else begin
            n_a++;
            exp_a = model_a(n_a);
            if (exp_a.pix_en) q_a.push_back({exp_a.x, exp_a.y, exp_a.active, exp_a.hs, exp_a.vs});
         end
      end
   end

   // Expectation generator B
   initial begin
      n_b   = 0;
      exp_b = model_b(0);
      forever begin
         @(posedge clk or negedge rst_n_b);
         if (!rst_n_b) begin
            check("drained_at_reset_b", q_b.size(), 0);
            q_b.delete();
            n_b   = 0;
            exp_b = model_b(0);
         end else begin
            n_b++;
            exp_b = model_b(n_b);
            if (exp_b.pix_en) q_b.push_back({exp_b.x, exp_b.y, exp_b.active, exp_b.hs, exp_b.vs});
         end
      end
   end

   // Monitor A: per-cycle compare, and pop the scoreboard on every presented tick
   initial forever begin
      obs_t  o;
      tick_t t;
      @(negedge clk);
      o = {pix_en_a, x_a, y_a, active_a, hs_a, vs_a, ls_a, fs_a};
      check_obs("cycle_a", o, exp_a);
      if (pix_en_a) begin
         total++;
         if (q_a.size() == 0) begin
            bad++;
            $display("FAIL tick_a @%0d: got unexpected tick at x=%0d y=%0d, expected no tick", cyc, x_a, y_a);
         end else begin
            t = q_a.pop_front();
            if ({x_a, y_a, active_a, hs_a, vs_a} !== t) begin
               bad++;
               $display("FAIL tick_a @%0d: got x=%0d y=%0d act=%0b hs=%0b vs=%0b, expected x=%0d y=%0d act=%0b hs=%0b vs=%0b",
                        cyc, x_a, y_a, active_a, hs_a, vs_a, t.x, t.y, t.active, t.hs, t.vs);
            end
         end
      end
      if (ls_a) $display("line a: y=%0d frame_start=%0b cycle=%0d", y_a, fs_a, cyc);
   end

   // Monitor B
   initial forever begin
      obs_t  o;
      tick_t t;
      @(negedge clk);
      o = {pix_en_b, x_b, y_b, active_b, hs_b, vs_b, ls_b, fs_b};
      check_obs("cycle_b", o, exp_b);
      if (pix_en_b) begin
         total++;
         if (q_b.size() == 0) begin
            bad++;
            $display("FAIL tick_b @%0d: got unexpected tick at x=%0d y=%0d, expected no tick", cyc, x_b, y_b);
         end else begin
            t = q_b.pop_front();
            if ({x_b, y_b, active_b, hs_b, vs_b} !== t) begin
               bad++;
               $display("FAIL tick_b @%0d: got x=%0d y=%0d act=%0b hs=%0b vs=%0b, expected x=%0d y=%0d act=%0b hs=%0b vs=%0b",
                        cyc, x_b, y_b, active_b, hs_b, vs_b, t.x, t.y, t.active, t.hs, t.vs);
            end
         end
      end
      if (ls_b) $display("line b: y=%0d frame_start=%0b cycle=%0d", y_b, fs_b, cyc);
   end

   initial begin
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      repeat (10) @(negedge clk);
      fork
         // ---------------- default 640x480, CLK_DIV=4 ----------------
         begin
            int rel, k, hs_cnt, fall_x, t1, t2, found;
            rst_n_a = 1'b1;
            rel = cyc;
            k = -1;
            for (int i = 1; i <= 20; i++) begin
               @(negedge clk);
               if (pix_en_a) begin k = i; break; end
            end
            check("first_pix_en_a", k, 3);
            hs_cnt = 0; fall_x = -1; t1 = -1;
            for (int i = 0; i < 4000; i++) begin
               @(negedge clk);
               if (ls_a) begin t1 = cyc; break; end
               if (hs_a == 1'b0) hs_cnt++;
               if (!active_a && fall_x < 0) fall_x = int'(x_a);
            end
            check("hs_cycles_line0_a", hs_cnt, 384);
            check("active_fall_x_a", fall_x, 640);
            check("first_line_start_a", t1 - rel, 3200);
            t2 = -1;
            for (int i = 0; i < 4000; i++) begin
               @(negedge clk);
               if (ls_a) begin t2 = cyc; break; end
            end
            check("line_period_a", t2 - t1, 3200);
            found = 0;
            for (int i = 0; i < 2000; i++) begin
               @(negedge clk);
               if (x_a == 10'd300 && y_a == 10'd2) begin found = 1; break; end
            end
            check("reach_x300_a", found, 1);
            #2 rst_n_a = 1'b0;
            #1;
            check("async_rst_pix_en_a", int'(pix_en_a), 0);
            check("async_rst_x_a", int'(x_a), 0);
            check("async_rst_y_a", int'(y_a), 0);
            check("async_rst_active_a", int'(active_a), 1);
            check("async_rst_hs_a", int'(hs_a), 1);
            check("async_rst_vs_a", int'(vs_a), 1);
            check("async_rst_ls_a", int'(ls_a), 0);
            check("async_rst_fs_a", int'(fs_a), 0);
            repeat (4) @(negedge clk);
            rst_n_a = 1'b1;
            rel = cyc;
            t1 = -1;
            for (int i = 0; i < 4000; i++) begin
               @(negedge clk);
               if (ls_a) begin t1 = cyc; break; end
            end
            check("restart_line_start_a", t1 - rel, 3200);
            repeat (8) @(negedge clk);
         end
         // ---------------- tiny 20x8, CLK_DIV=1, positive sync ----------------
         begin
            int rel, t1, t2, f1, f2, vs_cnt, ls_cnt, y_max, en_low, found;
            rst_n_b = 1'b1;
            rel = cyc;
            t1 = -1; en_low = 0;
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               if (!pix_en_b) en_low++;
               if (ls_b) begin t1 = cyc; break; end
            end
            check("first_line_start_b", t1 - rel, 21);
            t2 = -1;
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               if (!pix_en_b) en_low++;
               if (ls_b) begin t2 = cyc; break; end
            end
            check("line_period_b", t2 - t1, 20);
            f1 = -1;
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (!pix_en_b) en_low++;
               if (fs_b) begin f1 = cyc; break; end
            end
            check("first_frame_start_b", f1 - rel, 161);
            f2 = -1; vs_cnt = 0; ls_cnt = 0; y_max = 0;
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (!pix_en_b) en_low++;
               if (ls_b) ls_cnt++;
               if (fs_b) begin f2 = cyc; break; end
               if (vs_b) vs_cnt++;
               if (int'(y_b) > y_max) y_max = int'(y_b);
            end
            check("frame_period_b", f2 - f1, 160);
            check("vs_cycles_b", vs_cnt, 40);
            check("line_starts_per_frame_b", ls_cnt, 8);
            check("y_max_b", y_max, 7);
            check("pix_en_low_cycles_b", en_low, 0);
            found = 0;
            for (int i = 0; i < 200; i++) begin
               @(negedge clk);
               if (x_b == 10'd7 && y_b == 10'd5) begin found = 1; break; end
            end
            check("reach_x7_y5_b", found, 1);
            #2 rst_n_b = 1'b0;
            #1;
            check("async_rst_pix_en_b", int'(pix_en_b), 0);
            check("async_rst_x_b", int'(x_b), 0);
            check("async_rst_y_b", int'(y_b), 0);
            check("async_rst_active_b", int'(active_b), 1);
            check("async_rst_hs_b", int'(hs_b), 0);
            check("async_rst_vs_b", int'(vs_b), 0);
            repeat (3) @(negedge clk);
            rst_n_b = 1'b1;
            rel = cyc;
            t1 = -1;
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               if (ls_b) begin t1 = cyc; break; end
            end
            check("restart_line_start_b", t1 - rel, 21);
            repeat (200) @(negedge clk);
         end
      join
      #1;
      check("drain_end_a", q_a.size(), 0);
      check("drain_end_b", q_b.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
